// File: rtl/disp_arb_pkg.sv
// Shared types and constants for the front-panel display arbiter.
package disp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2,
    BLANK = 2'd3
  } state_t;

  localparam logic [1:0] SU  = 2'd0;
  localparam logic [1:0] ERR = 2'd1;
  localparam logic [1:0] USR = 2'd2;

  localparam logic [2:0] GNT_NONE = 3'b000;
  localparam logic [2:0] GNT_SU   = 3'b001;
  localparam logic [2:0] GNT_ERR  = 3'b010;
  localparam logic [2:0] GNT_USR  = 3'b100;

  localparam logic [15:0] HOLD_CNT_DEF  = 16'd3000;
  localparam logic [15:0] BLANK_CNT_DEF = 16'd8;

  function automatic logic [2:0] idx_to_gnt(input logic [1:0] idx);
    case (idx)
      SU:      idx_to_gnt = GNT_SU;
      ERR:     idx_to_gnt = GNT_ERR;
      USR:     idx_to_gnt = GNT_USR;
      default: idx_to_gnt = GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/disp_hold_timer.sv
// Clearable 16-bit up-counter that saturates at the compare value and flags the match.
module disp_hold_timer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clr,
  input  logic        inc,
  input  logic [15:0] cmp,
  output logic        match
);

  logic [15:0] cnt_reg;

  assign match = (cnt_reg == cmp);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_reg <= 16'd0;
    end else if (clr) begin
      cnt_reg <= 16'd0;
    end else if (inc && !match) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Fixed-priority owner of the front-panel LED display with minimum hold and blank gap.
// Optional build macro DISP_ARB_PREEMPT_EN lets a higher-priority request cut Hold short.
module display_arbiter
  import disp_arb_pkg::*;
#(
  parameter logic [15:0] HOLD_CNT  = HOLD_CNT_DEF,
  parameter logic [15:0] BLANK_CNT = BLANK_CNT_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_SU,
  input  logic        REQ_ERR,
  input  logic        REQ_USR,
  input  logic [15:0] PAT_SU,
  input  logic [15:0] PAT_ERR,
  input  logic [15:0] PAT_USR,
  output logic [2:0]  GNT,
  output logic        DISP_EN,
  output logic [15:0] DISP_PAT,
  output logic        CLEAR
);

  // Hold counts 1..HOLD_LIM; Blank counts from 0 after its entry clear, hence the -1.
  localparam logic [15:0] HOLD_LIM  = (HOLD_CNT == 16'd0) ? 16'd1 : HOLD_CNT;
  localparam logic [15:0] BLANK_LIM = (BLANK_CNT == 16'd0) ? 16'd0 : BLANK_CNT - 16'd1;

  state_t      state_reg;
  logic [1:0]  owner_reg;
  logic [2:0]  gnt_reg;
  logic        disp_en_reg;
  logic [15:0] disp_pat_reg;
  logic        clear_reg;

  logic [1:0]  winner;
  logic [15:0] winner_pat;
  logic        any_req;
  logic        owner_req;
  logic [15:0] owner_pat;
  logic        higher_req;
  logic        hold_exit;
  logic        tmr_clr;
  logic        tmr_inc;
  logic [15:0] tmr_cmp;
  logic        tmr_match;

  always_comb begin
    any_req    = REQ_SU | REQ_ERR | REQ_USR;
    winner     = USR;
    winner_pat = PAT_USR;
    if (REQ_SU) begin
      winner     = SU;
      winner_pat = PAT_SU;
    end else if (REQ_ERR) begin
      winner     = ERR;
      winner_pat = PAT_ERR;
    end

    owner_req  = REQ_USR;
    owner_pat  = PAT_USR;
    higher_req = REQ_SU | REQ_ERR;
    case (owner_reg)
      SU: begin
        owner_req  = REQ_SU;
        owner_pat  = PAT_SU;
        higher_req = 1'b0;
      end
      ERR: begin
        owner_req  = REQ_ERR;
        owner_pat  = PAT_ERR;
        higher_req = REQ_SU;
      end
      default: ;
    endcase

`ifdef DISP_ARB_PREEMPT_EN
    hold_exit = higher_req || (tmr_match && !owner_req);
`else
    hold_exit = tmr_match && (higher_req || !owner_req);
`endif

    tmr_clr = (state_reg == IDLE) || ((state_reg == HOLD) && hold_exit);
    tmr_inc = (state_reg != IDLE);
    tmr_cmp = (state_reg == BLANK) ? BLANK_LIM : HOLD_LIM;
  end

  disp_hold_timer u_timer (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .cmp   (tmr_cmp),
    .match (tmr_match)
  );

  // Outputs are assigned alongside each transition so they reflect the state being entered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      owner_reg    <= SU;
      gnt_reg      <= GNT_NONE;
      disp_en_reg  <= 1'b0;
      disp_pat_reg <= 16'd0;
      clear_reg    <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg    <= GRANT;
            owner_reg    <= winner;
            gnt_reg      <= idx_to_gnt(winner);
            disp_pat_reg <= winner_pat;
            clear_reg    <= 1'b0;
          end
        end
        GRANT: begin
          state_reg   <= HOLD;
          disp_en_reg <= 1'b1;
          if (owner_req) disp_pat_reg <= owner_pat;
        end
        HOLD: begin
          if (hold_exit) begin
            state_reg    <= BLANK;
            gnt_reg      <= GNT_NONE;
            disp_en_reg  <= 1'b0;
            disp_pat_reg <= 16'd0;
            clear_reg    <= 1'b1;
          end else if (owner_req) begin
            disp_pat_reg <= owner_pat;
          end
        end
        BLANK: begin
          if (tmr_match) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign GNT      = gnt_reg;
  assign DISP_EN  = disp_en_reg;
  assign DISP_PAT = disp_pat_reg;
  assign CLEAR    = clear_reg;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: expected outputs are queued as stimulus is applied
// and checked after each edge (main DUT HOLD=4/BLANK=2, second DUT HOLD=0/BLANK=0).
module tb_display_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_SU, REQ_ERR, REQ_USR;
  logic [15:0] PAT_SU, PAT_ERR, PAT_USR;
  logic [2:0]  GNT, GNT_Z;
  logic        DISP_EN, DISP_EN_Z;
  logic [15:0] DISP_PAT, DISP_PAT_Z;
  logic        CLEAR, CLEAR_Z;

  localparam logic [2:0] G0 = 3'b000, GS = 3'b001, GE = 3'b010, GU = 3'b100;

  always #5 CLK = ~CLK;

  display_arbiter #(.HOLD_CNT(16'd4), .BLANK_CNT(16'd2)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_SU(REQ_SU), .REQ_ERR(REQ_ERR), .REQ_USR(REQ_USR),
    .PAT_SU(PAT_SU), .PAT_ERR(PAT_ERR), .PAT_USR(PAT_USR),
    .GNT(GNT), .DISP_EN(DISP_EN), .DISP_PAT(DISP_PAT), .CLEAR(CLEAR)
  );

  display_arbiter #(.HOLD_CNT(16'd0), .BLANK_CNT(16'd0)) dut_z (
    .CLK(CLK), .RST(RST),
    .REQ_SU(REQ_SU), .REQ_ERR(REQ_ERR), .REQ_USR(REQ_USR),
    .PAT_SU(PAT_SU), .PAT_ERR(PAT_ERR), .PAT_USR(PAT_USR),
    .GNT(GNT_Z), .DISP_EN(DISP_EN_Z), .DISP_PAT(DISP_PAT_Z), .CLEAR(CLEAR_Z)
  );

  logic [20:0] exp_q[$];
  string       tag_q[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;

  task automatic compare(input logic z);
    logic [20:0] obs;
    logic [20:0] expv;
    string       tag;
    obs  = z ? {GNT_Z, DISP_EN_Z, DISP_PAT_Z, CLEAR_Z} : {GNT, DISP_EN, DISP_PAT, CLEAR};
    expv = exp_q.pop_front();
    tag  = tag_q.pop_front();
    vec_cnt++;
    assert (obs === expv) else begin
      err_cnt++;
      $error("FAIL %s: observed gnt/en/pat/clr=%b/%b/%h/%b expected %b/%b/%h/%b",
             tag, obs[20:18], obs[17], obs[16:1], obs[0],
             expv[20:18], expv[17], expv[16:1], expv[0]);
    end
    $display("%s dut%0s gnt=%b en=%b pat=%h clr=%b", tag, z ? "_z" : "",
             obs[20:18], obs[17], obs[16:1], obs[0]);
  endtask

  task automatic push(input string tag, input logic [2:0] g, input logic e,
                      input logic [15:0] p, input logic c);
    exp_q.push_back({g, e, p, c});
    tag_q.push_back(tag);
  endtask

  task automatic step(input string tag, input logic z, input logic [2:0] g, input logic e,
                      input logic [15:0] p, input logic c);
    push(tag, g, e, p, c);
    @(posedge CLK);
    #1;
    compare(z);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n_more;
    RST = 1'b1;
    REQ_SU = 1'b1; REQ_ERR = 1'b0; REQ_USR = 1'b0;
    PAT_SU = 16'h1234; PAT_ERR = 16'h0000; PAT_USR = 16'h0000;

    // 1: reset with REQ_SU held, then grant/enable latency and pattern tracking
    step("t1_rst0", 0, G0, 0, 16'h0000, 1);
    step("t1_rst1", 0, G0, 0, 16'h0000, 1);
    RST = 1'b0;
    step("t1_grant", 0, GS, 0, 16'h1234, 0);
    step("t1_hold1", 0, GS, 1, 16'h1234, 0);
    PAT_SU = 16'h5678;
    step("t1_track", 0, GS, 1, 16'h5678, 0);
    REQ_SU = 1'b0; PAT_SU = 16'h9999;
    step("t1_frz3", 0, GS, 1, 16'h5678, 0);
    step("t1_frz4", 0, GS, 1, 16'h5678, 0);
    step("t1_blank1", 0, G0, 0, 16'h0000, 1);
    step("t1_blank2", 0, G0, 0, 16'h0000, 1);
    step("t1_idle", 0, G0, 0, 16'h0000, 1);

    // 2: one-cycle USR pulse holds exactly 4 cycles with frozen pattern
    REQ_USR = 1'b1; PAT_USR = 16'hA5A5;
    step("t2_grant", 0, GU, 0, 16'hA5A5, 0);
    REQ_USR = 1'b0; PAT_USR = 16'h0000;
    for (int i = 0; i < 4; i++) step("t2_hold", 0, GU, 1, 16'hA5A5, 0);
    step("t2_blank1", 0, G0, 0, 16'h0000, 1);
    step("t2_blank2", 0, G0, 0, 16'h0000, 1);
    step("t2_idle", 0, G0, 0, 16'h0000, 1);

    // 3: ERR beats USR; USR waits past hold_done until ERR releases
    REQ_ERR = 1'b1; REQ_USR = 1'b1; PAT_ERR = 16'h0E0E; PAT_USR = 16'h0A0A;
    step("t3_grant", 0, GE, 0, 16'h0E0E, 0);
    for (int i = 0; i < 5; i++) step("t3_hold", 0, GE, 1, 16'h0E0E, 0);
    REQ_ERR = 1'b0;
    step("t3_blank1", 0, G0, 0, 16'h0000, 1);
    step("t3_blank2", 0, G0, 0, 16'h0000, 1);
    step("t3_idle", 0, G0, 0, 16'h0000, 1);
    step("t3_usr_grant", 0, GU, 0, 16'h0A0A, 0);
    step("t4_hold1", 0, GU, 1, 16'h0A0A, 0);

    // 4: SU arrives at USR Hold cycle 1
    REQ_SU = 1'b1; PAT_SU = 16'h00FF;
`ifdef DISP_ARB_PREEMPT_EN
    n_more = 0;
`else
    n_more = 3;
`endif
    for (int i = 0; i < n_more; i++) step("t4_hold", 0, GU, 1, 16'h0A0A, 0);
    step("t4_blank1", 0, G0, 0, 16'h0000, 1);
    step("t4_blank2", 0, G0, 0, 16'h0000, 1);
    step("t4_idle", 0, G0, 0, 16'h0000, 1);
    step("t4_su_grant", 0, GS, 0, 16'h00FF, 0);
    step("t6_hold1", 0, GS, 1, 16'h00FF, 0);

    // 6: asynchronous reset in the middle of a clock period
    #3;
    RST = 1'b1;
    #1;
    push("t6_async", G0, 0, 16'h0000, 1);
    compare(0);
    step("t6_rst", 0, G0, 0, 16'h0000, 1);
    RST = 1'b0;
    step("t6_regrant", 0, GS, 0, 16'h00FF, 0);
    step("t6_rehold", 0, GS, 1, 16'h00FF, 0);
    REQ_SU = 1'b0; REQ_USR = 1'b0;
    repeat (12) @(posedge CLK);
    #1;
    push("t6_settle", G0, 0, 16'h0000, 1);
    compare(0);

    // 5: zero HOLD_CNT/BLANK_CNT behave as one cycle each
    REQ_ERR = 1'b1; PAT_ERR = 16'h0E0E;
    step("t5_grant", 1, GE, 0, 16'h0E0E, 0);
    REQ_ERR = 1'b0;
    step("t5_hold", 1, GE, 1, 16'h0E0E, 0);
    step("t5_blank", 1, G0, 0, 16'h0000, 1);
    REQ_ERR = 1'b1;
    step("t5_idle", 1, G0, 0, 16'h0000, 1);
    step("t5_regrant", 1, GE, 0, 16'h0E0E, 0);
    REQ_ERR = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
